instruction_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the microcontroller datapath: PC, instruction memory, instruction decoder, register bank and ALU. It replaces the free-running PC plus delayed-clock scheme. Instead, it steps each instruction through fetch, memory wait, decode, execute and write-back on a single clock, and generates explicit enables. It also owns the PC, the instruction register, latched ALU flags, control flow (jump/branch/halt) and run/single-step control.

---
 rtl/instruction_sequencer_if.sv | 34 +++
 rtl/instruction_sequencer.sv | 107 ++++++++++
 tb/tb_instruction_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - sequencer datapath/control bundle
// master: the sequencer; slave: memory, decoder, ALU and run control around it.
interface instruction_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   i_RUN;
  logic                   i_STEP;
  logic [INSTR_WIDTH-1:0] i_INSTR;
  logic                   i_WriteBack;
  logic                   i_Z;
  logic                   i_C;
  logic [PC_WIDTH-1:0]    o_PC;
  logic [INSTR_WIDTH-1:0] o_IR;
  logic                   o_MemEn;
  logic                   o_RegWrite;
  logic                   o_FlagZ;
  logic                   o_FlagC;
  logic                   o_Halted;
  logic [2:0]             o_State;
  logic [15:0]            o_InstrCount;

  modport master (
    input  i_RUN, i_STEP, i_INSTR, i_WriteBack, i_Z, i_C,
    output o_PC, o_IR, o_MemEn, o_RegWrite, o_FlagZ, o_FlagC,
           o_Halted, o_State, o_InstrCount
  );

  modport slave (
    output i_RUN, i_STEP, i_INSTR, i_WriteBack, i_Z, i_C,
    input  o_PC, o_IR, o_MemEn, o_RegWrite, o_FlagZ, o_FlagC,
           o_Halted, o_State, o_InstrCount
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/wait/decode/exec/wb control FSM
// Owns PC, IR, latched flags, retired count and run/step/halt control.
module instruction_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  instruction_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_BRC  = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  logic [1:0] wait_cnt;
  logic [3:0] opcode;
  logic       is_alu;
  logic       taken;

  assign opcode = bus.o_IR[INSTR_WIDTH-1 -: 4];
  assign is_alu = (opcode <= 4'hB);
  // Branches look only at flags latched by earlier ALU ops, never live i_Z/i_C.
  assign taken  = (opcode == OP_JMP) ||
                  ((opcode == OP_BRZ) && bus.o_FlagZ) ||
                  ((opcode == OP_BRC) && bus.o_FlagC);

  assign bus.o_State = state;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state            <= IDLE;
      wait_cnt         <= 2'd0;
      bus.o_PC         <= '0;
      bus.o_IR         <= '0;
      bus.o_FlagZ      <= 1'b0;
      bus.o_FlagC      <= 1'b0;
      bus.o_InstrCount <= 16'd0;
      bus.o_MemEn      <= 1'b0;
      bus.o_RegWrite   <= 1'b0;
      bus.o_Halted     <= 1'b0;
    end else begin
      bus.o_MemEn    <= 1'b0;
      bus.o_RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_RUN || bus.i_STEP) begin
            state       <= FETCH;
            bus.o_MemEn <= 1'b1;
          end
        end
        FETCH: begin
          state    <= WAIT;
          wait_cnt <= 2'd0;
        end
        WAIT: begin
          if (wait_cnt == 2'(MEM_LATENCY - 1)) begin
            bus.o_IR <= bus.i_INSTR;
            state    <= DECODE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          if (opcode == OP_HALT) begin
            state        <= HALT;
            bus.o_Halted <= 1'b1;
          end else begin
            if (is_alu) begin
              bus.o_FlagZ <= bus.i_Z;
              bus.o_FlagC <= bus.i_C;
            end
            bus.o_RegWrite <= is_alu && bus.i_WriteBack;
            state          <= WB;
          end
        end
        WB: begin
          bus.o_PC         <= taken ? PC_WIDTH'(bus.o_IR[7:0]) : bus.o_PC + PC_WIDTH'(1);
          bus.o_InstrCount <= bus.o_InstrCount + 16'd1;
          if (bus.i_RUN) begin
            state       <= FETCH;
            bus.o_MemEn <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
// Two DUTs (memory latency 1 and 3) run the same program against a reference ISA model.
module tb_instruction_sequencer;

  typedef struct {
    logic        h;
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic        z;
    logic        c;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run [2];
  logic        step;
  logic [15:0] instr_r [2];
  logic [15:0] mem [256];

  logic [7:0]  pc_w  [2];
  logic [2:0]  st_w  [2];
  logic        me_w  [2];
  logic        h_w   [2];
  logic [15:0] cnt_w [2];

  logic [7:0]  fq [2][$];
  logic [7:0]  wq [2][$];
  ret_t        rq [2][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic        m_z, m_c, m_h;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, g, a, e);
    end
  endtask

  task automatic flag_fail(input string nm, input int g, input string what);
    total++;
    bad++;
    $display("FAIL %s[%0d] got=%s want=none", nm, g, what);
  endtask

  for (genvar gv = 0; gv < 2; gv++) begin : gi
    localparam int L = (gv == 0) ? 1 : 3;

    instruction_sequencer_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) b ();

    instruction_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16), .MEM_LATENCY(L)) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (b.master)
    );

    assign b.i_RUN       = run[gv];
    assign b.i_STEP      = step;
    assign b.i_INSTR     = instr_r[gv];
    assign b.i_WriteBack = b.o_IR[10];
    assign b.i_Z         = b.o_IR[8];
    assign b.i_C         = b.o_IR[9];
    assign pc_w[gv]      = b.o_PC;
    assign st_w[gv]      = b.o_State;
    assign me_w[gv]      = b.o_MemEn;
    assign h_w[gv]       = b.o_Halted;
    assign cnt_w[gv]     = b.o_InstrCount;

    // Memory returns real data only in the last wait cycle; junk otherwise.
    initial begin : memm
      int k;
      k = 100;
      instr_r[gv] = 16'h0;
      forever begin
        @(posedge clk);
        #1;
        if (b.o_MemEn) k = 0;
        else if (k < 100) k++;
        instr_r[gv] = (k == L) ? mem[b.o_PC] : 16'($urandom);
      end
    end

    initial begin : mon
      int          last_mem;
      logic [15:0] pcnt;
      logic        ph;
      ret_t        r;
      logic [7:0]  p;
      last_mem = 0;
      pcnt     = 16'h0;
      ph       = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pcnt = 16'h0;
          ph   = 1'b0;
        end else begin
          if (b.o_InstrCount != pcnt) begin
            pcnt = b.o_InstrCount;
            if (rq[gv].size() == 0) flag_fail("retire", gv, "spurious");
            else begin
              r = rq[gv].pop_front();
              chk("ret_kind", gv, 0, r.h);
              chk("ret_pc", gv, b.o_PC, r.pc);
              chk("ret_cnt", gv, b.o_InstrCount, r.cnt);
              chk("ret_flagz", gv, b.o_FlagZ, r.z);
              chk("ret_flagc", gv, b.o_FlagC, r.c);
              chk("ret_lat", gv, cyc - last_mem, L + 4);
            end
          end
          if (b.o_Halted && !ph) begin
            if (rq[gv].size() == 0) flag_fail("halt", gv, "spurious");
            else begin
              r = rq[gv].pop_front();
              chk("halt_kind", gv, 1, r.h);
              chk("halt_pc", gv, b.o_PC, r.pc);
              chk("halt_cnt", gv, b.o_InstrCount, r.cnt);
              chk("halt_state", gv, b.o_State, 6);
              chk("halt_lat", gv, cyc - last_mem, L + 3);
            end
          end
          ph = b.o_Halted;
          if (b.o_RegWrite) begin
            if (wq[gv].size() == 0) flag_fail("regwrite", gv, "spurious");
            else begin
              p = wq[gv].pop_front();
              chk("wr_pc", gv, b.o_PC, p);
              chk("wr_lat", gv, cyc - last_mem, L + 3);
            end
          end
          if (b.o_MemEn) begin
            if (fq[gv].size() == 0) flag_fail("memen", gv, "spurious");
            else begin
              p = fq[gv].pop_front();
              chk("fetch_pc", gv, b.o_PC, p);
            end
            last_mem = cyc;
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_pc = 8'h0; m_cnt = 16'h0; m_z = 1'b0; m_c = 1'b0; m_h = 1'b0;
    for (int g = 0; g < 2; g++) begin
      fq[g].delete(); wq[g].delete(); rq[g].delete();
    end
  endtask

  // Architectural model: one call executes one instruction at m_pc.
  task automatic model_step();
    logic [15:0] ir;
    logic [3:0]  op;
    logic        tk;
    ret_t        r;
    ir = mem[m_pc];
    op = ir[15:12];
    for (int g = 0; g < 2; g++) fq[g].push_back(m_pc);
    if (op == 4'hF) begin
      m_h = 1'b1;
      r = '{1'b1, m_pc, m_cnt, m_z, m_c};
    end else begin
      if (op <= 4'hB) begin
        m_z = ir[8];
        m_c = ir[9];
        if (ir[10]) for (int g = 0; g < 2; g++) wq[g].push_back(m_pc);
      end
      tk = (op == 4'hE) || (op == 4'hD && m_z) || (op == 4'hC && m_c);
      m_pc  = tk ? ir[7:0] : m_pc + 8'd1;
      m_cnt = m_cnt + 16'd1;
      r = '{1'b0, m_pc, m_cnt, m_z, m_c};
    end
    for (int g = 0; g < 2; g++) rq[g].push_back(r);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    logic done;
    t = 0;
    done = 1'b0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      done = 1'b1;
      for (int g = 0; g < 2; g++)
        if (fq[g].size() != 0 || wq[g].size() != 0 || rq[g].size() != 0 ||
            !(st_w[g] == 3'd0 || st_w[g] == 3'd6)) done = 1'b0;
    end
    if (!done) flag_fail("idle_timeout", 0, "busy");
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    int ne, t;
    int got [2];
    ne = 0;
    for (int i = 0; i < n; i++) if (!m_h) begin model_step(); ne++; end
    if (ne == 0) return;
    got[0] = 0; got[1] = 0; t = 0;
    run[0] = 1'b1; run[1] = 1'b1;
    while ((got[0] < ne || got[1] < ne) && t < 1000) begin
      @(negedge clk);
      t++;
      for (int g = 0; g < 2; g++) if (me_w[g] && got[g] < ne) begin
        if (got[g] == 0) chk("start_lat", g, t, 1);
        got[g]++;
        if (got[g] == ne) run[g] = 1'b0;
      end
    end
    if (t >= 1000) flag_fail("run_timeout", 0, "stuck");
    run[0] = 1'b0; run[1] = 1'b0;
    wait_idle();
  endtask

  task automatic step_one();
    if (m_h) return;
    model_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1; run[0] = 1'b0; run[1] = 1'b0; step = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    do_reset(3);
    for (int g = 0; g < 2; g++) begin
      chk("rst_state", g, st_w[g], 0);
      chk("rst_pc", g, pc_w[g], 0);
      chk("rst_cnt", g, cnt_w[g], 0);
      chk("rst_memen", g, me_w[g], 0);
      chk("rst_halted", g, h_w[g], 0);
    end

    // Directed: ALU, BRZ taken, ALU, BRZ not taken, JMP, BRC taken, wrap at 0xFF.
    mem[8'h00] = 16'h1500;
    mem[8'h01] = 16'hD010;
    mem[8'h10] = 16'h0200;
    mem[8'h11] = 16'hD320;
    mem[8'h12] = 16'hE340;
    mem[8'h40] = 16'hC0FF;
    mem[8'hFF] = 16'h27AB;
    run_n(5);
    step_one();
    step_one();
    for (int g = 0; g < 2; g++) begin
      chk("wrap_pc", g, pc_w[g], 0);
      chk("wrap_state", g, st_w[g], 0);
      chk("wrap_cnt", g, cnt_w[g], 7);
    end

    // Randomized program, mixed single-step and free-run bursts.
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 14));
      mem[i] = {op, 12'($urandom)};
    end
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 2) == 0) step_one();
      else run_n($urandom_range(1, 8));
    end

    // Reset while an instruction sits in WAIT.
    for (int g = 0; g < 2; g++) fq[g].push_back(m_pc);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("wrst_pc", g, pc_w[g], 0);
      chk("wrst_state", g, st_w[g], 0);
      chk("wrst_memen", g, me_w[g], 0);
      chk("wrst_cnt", g, cnt_w[g], 0);
    end
    repeat (3) @(negedge clk);

    // HALT at 0x07 after seven ALU ops; run/step must then be ignored.
    for (int i = 0; i < 7; i++) begin
      op = 4'($urandom_range(0, 11));
      mem[i] = {op, 12'($urandom)};
    end
    mem[7] = 16'hF000;
    run_n(10);
    for (int i = 0; i < 20; i++) begin
      run[0] = 1'($urandom); run[1] = 1'($urandom); step = 1'($urandom);
      @(negedge clk);
    end
    run[0] = 1'b0; run[1] = 1'b0; step = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("hold_pc", g, pc_w[g], 8'h07);
      chk("hold_state", g, st_w[g], 6);
      chk("hold_halted", g, h_w[g], 1);
      chk("hold_cnt", g, cnt_w[g], 7);
    end
    do_reset(1);
    for (int g = 0; g < 2; g++) begin
      chk("unhalt_state", g, st_w[g], 0);
      chk("unhalt_halted", g, h_w[g], 0);
      chk("unhalt_pc", g, pc_w[g], 0);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
